// File: rtl/hs_cdc_syncer_gray_mc_pkg.sv
// Shared constants and helpers for the multi-channel Gray-code synchronizer.
//   gray2bin : Gray -> binary for any width up to 32 (zero-extend the input).
package hs_cdc_syncer_gray_mc_pkg;

  localparam int SYNC_STAGE_MIN = 2;
  localparam int SYNC_STAGE_MAX = 32;
  localparam int CHANNELS_MIN   = 1;
  localparam int CHANNELS_MAX   = 16;
  localparam int WIDTH_MIN      = 2;
  localparam int WIDTH_MAX      = 32;

  // Zero upper bits decode to zero, so one 32-bit routine serves every width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/hs_cdc_syncer_gray_mc_if.sv
// Bus between a source-side owner and the Gray-code synchronizer.
//   din/err_clr flow into the synchronizer (slave); dout/delta/upd/overrun/primed flow out.
interface hs_cdc_syncer_gray_mc_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [CHANNELS-1:0]       err_clr;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS*WIDTH-1:0] delta;
  logic [CHANNELS-1:0]       upd;
  logic [CHANNELS-1:0]       overrun;
  logic                      primed;

  modport master (output din, err_clr, input dout, delta, upd, overrun, primed);
  modport slave  (input din, err_clr, output dout, delta, upd, overrun, primed);
endinterface

// File: rtl/hs_cdc_syncer_gray_mc_chan.sv
// One channel: SYNC_STAGE-deep Gray synchronizer, decode, delta/upd/overrun regs.
//   din      Gray code from the foreign domain
//   err_clr  clears overrun (a same-cycle overrun event wins)
//   primed   run enable from the shared prime counter
//   load     one-cycle strobe that silently loads the initial value
//   dout/delta/upd/overrun  registered results
module hs_cdc_syncer_gray_mc_chan
  import hs_cdc_syncer_gray_mc_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          SYNC_STAGE = 2,
  parameter int unsigned MAX_DELTA  = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  input  logic             primed,
  input  logic             load,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] delta,
  output logic             upd,
  output logic             overrun
);

  logic [SYNC_STAGE-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] b_s, b_pre, d;
  logic             over;

  always_ff @(posedge clk or posedge areset)
    if (areset) sync <= '0;
    else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_STAGE; i++) sync[i] <= sync[i-1];
    end

  assign b_s   = WIDTH'(gray2bin(32'(sync[SYNC_STAGE-1])));
  // The load edge takes the value entering the last stage, i.e. what g_s
  // becomes on that same edge, so the first run compare sees d == 0.
  assign b_pre = WIDTH'(gray2bin(32'(sync[SYNC_STAGE-2])));
  assign d     = b_s - dout;
  assign over  = primed && (32'(d) > MAX_DELTA);

  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      dout    <= '0;
      delta   <= '0;
      upd     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (load) dout <= b_pre;
      else if (primed && d != '0) begin
        dout  <= b_s;
        delta <= d;
        upd   <= 1'b1;
      end
      if (over)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end

  a_upd_delta: assert property (@(posedge clk) disable iff (areset) upd |-> delta != '0);

endmodule

// File: rtl/hs_cdc_syncer_gray_mc.sv
// Multi-channel destination-side synchronizer for Gray-coded counters.
//   clk, areset  destination clock, async active-high reset
//   bus          slave side of hs_cdc_syncer_gray_mc_if (din/err_clr in,
//                dout/delta/upd/overrun/primed out)
// A shared counter waits SYNC_STAGE edges after reset, then loads every
// channel's initial value silently and raises primed.
module hs_cdc_syncer_gray_mc
  import hs_cdc_syncer_gray_mc_pkg::*;
#(
  parameter int          CHANNELS   = 2,
  parameter int          WIDTH      = 8,
  parameter int          SYNC_STAGE = 2,
  parameter int unsigned MAX_DELTA  = 1
) (
  input logic                    clk,
  input logic                    areset,
  hs_cdc_syncer_gray_mc_if.slave bus
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_ch
    $fatal(1, "CHANNELS out of range");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_w
    $fatal(1, "WIDTH out of range");
  end
  if (SYNC_STAGE < SYNC_STAGE_MIN || SYNC_STAGE > SYNC_STAGE_MAX) begin : g_bad_s
    $fatal(1, "SYNC_STAGE out of range");
  end
  if (MAX_DELTA < 1 || 64'(MAX_DELTA) > (64'd1 << WIDTH) - 64'd1) begin : g_bad_md
    $fatal(1, "MAX_DELTA out of range");
  end

  localparam int CW = $clog2(SYNC_STAGE + 1);

  logic [CW-1:0] cnt;
  logic          primed, load;

  assign load = !primed && (cnt == CW'(SYNC_STAGE - 1));

  // Counts up to SYNC_STAGE and stops there.
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (!primed) begin
      cnt <= cnt + 1'b1;
      if (load) primed <= 1'b1;
    end

  logic [CHANNELS-1:0][WIDTH-1:0] din_a, dout_a, delta_a;
  logic [CHANNELS-1:0]            upd_a, ovr_a;

  assign din_a = bus.din;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    hs_cdc_syncer_gray_mc_chan #(
      .WIDTH(WIDTH), .SYNC_STAGE(SYNC_STAGE), .MAX_DELTA(MAX_DELTA)
    ) u_chan (
      .clk     (clk),
      .areset  (areset),
      .din     (din_a[c]),
      .err_clr (bus.err_clr[c]),
      .primed  (primed),
      .load    (load),
      .dout    (dout_a[c]),
      .delta   (delta_a[c]),
      .upd     (upd_a[c]),
      .overrun (ovr_a[c])
    );
  end

  assign bus.dout    = dout_a;
  assign bus.delta   = delta_a;
  assign bus.upd     = upd_a;
  assign bus.overrun = ovr_a;
  assign bus.primed  = primed;

endmodule

// File: tb/tb_hs_cdc_syncer_gray_mc.sv
// Directed + randomized bench. The reference model treats the synchronizer as
// a pure delay on the source count: a run edge sees the count driven
// SYNC_STAGE+1 edges earlier, the load edge the count driven SYNC_STAGE edges earlier.
module tb_hs_cdc_syncer_gray_mc;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int MAXD = 1;

  typedef logic [W-1:0] vals_t [CH];

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  hs_cdc_syncer_gray_mc_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  hs_cdc_syncer_gray_mc #(
    .CHANNELS(CH), .WIDTH(W), .SYNC_STAGE(SYNC), .MAX_DELTA(MAXD)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  logic [W-1:0] src [CH];
  always_comb begin
    bus.din = '0;
    for (int c = 0; c < CH; c++) bus.din[c*W +: W] = src[c] ^ (src[c] >> 1);
  end

  int checks = 0;
  int errors = 0;

  vals_t        hist[$];
  logic [W-1:0] m_dout [CH];
  logic [W-1:0] m_delta[CH];
  logic         m_upd  [CH];
  logic         m_ovr  [CH];
  logic         m_primed;
  int           e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("dout%0d e%0d", c, e),  32'(bus.dout[c*W +: W]),  32'(m_dout[c]));
      chk($sformatf("delta%0d e%0d", c, e), 32'(bus.delta[c*W +: W]), 32'(m_delta[c]));
      chk($sformatf("upd%0d e%0d", c, e),   32'(bus.upd[c]),          32'(m_upd[c]));
      chk($sformatf("ovr%0d e%0d", c, e),   32'(bus.overrun[c]),      32'(m_ovr[c]));
    end
    chk($sformatf("primed e%0d", e), 32'(bus.primed), 32'(m_primed));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #1;
    hist.delete();
    e = 0;
    m_primed = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_dout[c] = '0; m_delta[c] = '0; m_upd[c] = 1'b0; m_ovr[c] = 1'b0;
    end
    chk_all();
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic tick();
    vals_t        cur;
    logic [CH-1:0] clr;
    logic [W-1:0]  v, d;
    for (int c = 0; c < CH; c++) cur[c] = src[c];
    hist.push_back(cur);
    clr = bus.err_clr;
    @(posedge clk);
    e++;
    for (int c = 0; c < CH; c++) begin
      m_upd[c] = 1'b0;
      if (e > SYNC) begin
        v = hist[e-SYNC-1][c];
        d = v - m_dout[c];
        if (d != 0) begin
          m_dout[c] = v; m_delta[c] = d; m_upd[c] = 1'b1;
        end
        if (int'(d) > MAXD) m_ovr[c] = 1'b1;
        else if (clr[c])    m_ovr[c] = 1'b0;
      end else begin
        if (e == SYNC) m_dout[c] = hist[e-SYNC][c];
        if (clr[c]) m_ovr[c] = 1'b0;
      end
    end
    if (e >= SYNC) m_primed = 1'b1;
    @(negedge clk);
    chk_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int pulses;
    int r;
    bus.err_clr = '0;
    for (int c = 0; c < CH; c++) src[c] = 8'(c * 16 + 3);
    @(negedge clk);

    // 1: silent prime of a nonzero value
    src[0] = 8'h37;
    do_reset();
    ticks(2);
    chk("t1 primed", 32'(bus.primed), 32'd1);
    chk("t1 dout0", 32'(bus.dout[W-1:0]), 32'h37);
    chk("t1 ovr0", 32'(bus.overrun[0]), 32'd0);
    ticks(2);

    // 2: +1 every 3 clocks, 0x00 -> 0x10
    src[0] = 8'h00;
    do_reset();
    ticks(4);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      src[0] = 8'(i);
      for (int k = 0; k < 3; k++) begin
        tick();
        if (bus.upd[0]) pulses++;
      end
    end
    chk("t2 pulses", 32'(pulses), 32'd16);
    chk("t2 ovr0", 32'(bus.overrun[0]), 32'd0);

    // 3: wrap-around
    src[0] = 8'hFE;
    do_reset();
    ticks(4);
    src[0] = 8'hFF; ticks(3);
    src[0] = 8'h00; ticks(3);
    chk("t3 dout0", 32'(bus.dout[W-1:0]), 32'h00);
    chk("t3 delta0", 32'(bus.delta[W-1:0]), 32'h01);
    chk("t3 ovr0", 32'(bus.overrun[0]), 32'd0);

    // 4: overrun, clear, and set-wins
    src[0] = 8'h10;
    do_reset();
    ticks(4);
    src[0] = 8'h13; ticks(3);
    chk("t4 delta0", 32'(bus.delta[W-1:0]), 32'h03);
    chk("t4 ovr0", 32'(bus.overrun[0]), 32'd1);
    ticks(2);
    bus.err_clr[0] = 1'b1; tick(); bus.err_clr[0] = 1'b0;
    chk("t4 cleared", 32'(bus.overrun[0]), 32'd0);
    src[0] = 8'h16; ticks(2);
    bus.err_clr[0] = 1'b1; tick(); bus.err_clr[0] = 1'b0;
    chk("t4 set wins", 32'(bus.overrun[0]), 32'd1);
    ticks(2);

    // 5: all channels step together
    for (int c = 0; c < CH; c++) src[c] = src[c] + 8'd1;
    ticks(3);
    chk("t5 upd all", 32'(bus.upd), 32'hF);

    // 6: reset mid-stream with dout = 0x42
    src[0] = 8'h42; ticks(4);
    do_reset();
    ticks(2);
    chk("t6 dout0", 32'(bus.dout[W-1:0]), 32'h42);
    chk("t6 ovr0", 32'(bus.overrun[0]), 32'd0);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      for (int c = 0; c < CH; c++) begin
        r = int'($urandom_range(0, 9));
        if (r < 5)       src[c] = src[c];
        else if (r < 8)  src[c] = src[c] + 8'd1;
        else if (r == 8) src[c] = src[c] + 8'd2;
        else             src[c] = src[c] + 8'($urandom_range(0, 255));
        bus.err_clr[c] = ($urandom_range(0, 5) == 0);
      end
      tick();
      if (i == 120) begin
        bus.err_clr = '0;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
